// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller: pops the TLP FIFO, absorbs its 1-cycle q_b latency in a 2-entry skid buffer.
// Pop to out_valid is 2 edges; under out_ready=0 at most 2 words are held and popping stops, nothing is lost.
module fifo_drain_ctrl #(
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 8,
  parameter int TO_W    = 4,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              fifo_empty,
  input  logic              fifo_almost_empty,
  input  logic              fifo_error,
  output logic              fifo_pop,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  word_count
);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [TO_W-1:0]   to_cnt;
  logic              to_hit;
  logic [DATA_W-1:0] buf0_dat;
  logic [DATA_W-1:0] buf1_dat;
  logic [1:0]        occ;
  logic              inflight;
  logic              deq;
  logic              pop_en;
  logic [2:0]        fill_now;
  logic [2:0]        fill_lim;

  assign to_hit    = (to_cnt == TO_W'(TIMEOUT));
  assign out_valid = (occ != 2'd0);
  assign out_data  = buf0_dat;
  assign deq       = out_valid && out_ready;

  // A dequeue this cycle frees a slot, so it may fund a pop in the same cycle.
  assign fill_now = {1'b0, occ} + {2'b00, inflight};
  assign fill_lim = 3'd2 + {2'b00, deq};
  assign fifo_pop = pop_en && !fifo_empty && (fill_now < fill_lim);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if ((!fifo_empty && !fifo_almost_empty) || to_hit) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && !inflight) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    pop_en = 1'b0;
    case (state)
      IDLE: begin
        busy   = 1'b0;
        pop_en = 1'b0;
      end
      DRAIN: begin
        busy   = 1'b1;
        pop_en = 1'b1;
      end
    endcase
  end

  // Idle timer only runs while a short residue sits in the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt <= '0;
    end else if (state != IDLE || state_nxt != IDLE || fifo_empty) begin
      to_cnt <= '0;
    end else if (!to_hit) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= 1'b0;
      occ      <= 2'd0;
      buf0_dat <= '0;
      buf1_dat <= '0;
    end else begin
      inflight <= fifo_pop;
      case ({inflight, deq})
        2'b10: begin
          if (occ == 2'd0) begin
            buf0_dat <= fifo_q;
          end else begin
            buf1_dat <= fifo_q;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0_dat <= buf1_dat;
          occ      <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0_dat <= fifo_q;
          end else begin
            buf0_dat <= buf1_dat;
            buf1_dat <= fifo_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      err <= err | fifo_error;
      if (deq) begin
        word_count <= word_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: behavioural FIFO on the read side, scoreboard of expected words on the consumer side.
module tb_fifo_drain_ctrl;

  localparam int DATA_W  = 4;
  localparam int TIMEOUT = 8;
  localparam int TO_W    = 4;
  localparam int CNT_W   = 8;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] fifo_q;
  logic              fifo_empty;
  logic              fifo_almost_empty;
  logic              fifo_error;
  logic              fifo_pop;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              err;
  logic [CNT_W-1:0]  word_count;

  fifo_drain_ctrl #(
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .fifo_q           (fifo_q),
    .fifo_empty       (fifo_empty),
    .fifo_almost_empty(fifo_almost_empty),
    .fifo_error       (fifo_error),
    .fifo_pop         (fifo_pop),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .err              (err),
    .word_count       (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [CNT_W-1:0]  exp_wc;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pop_cnt, deq_cnt, first_pop, last_pop, first_deq, last_deq, first_vld;
  bit saw_busy;
  logic              s_vld;
  logic [DATA_W-1:0] s_dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic set_flags();
    fifo_empty        = (mem.size() == 0);
    fifo_almost_empty = (mem.size() <= 2);
  endtask

  task automatic clear_stats();
    pop_cnt   = 0;
    deq_cnt   = 0;
    first_pop = -1;
    last_pop  = -1;
    first_deq = -1;
    last_deq  = -1;
    first_vld = -1;
    saw_busy  = 1'b0;
  endtask

  task automatic load_seq(input int first, input int n);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = DATA_W'(first + i);
      mem.push_back(w);
      exp_q.push_back(w);
      exp_wc = exp_wc + CNT_W'(1);
    end
    set_flags();
  endtask

  // One clock: sample DUT at the falling edge, then update the FIFO model and scoreboard just after the rising edge.
  task automatic step();
    logic p;
    logic d;
    @(negedge clk);
    p     = fifo_pop;
    d     = out_valid && out_ready;
    s_vld = out_valid;
    s_dat = out_data;
    if (busy) saw_busy = 1'b1;
    if (fifo_empty) chk("pop_when_empty", 32'(p), 32'd0);
    if (p) begin
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      pop_cnt++;
    end
    if (out_valid && first_vld < 0) first_vld = cyc;
    if (d) begin
      if (first_deq < 0) first_deq = cyc;
      last_deq = cyc;
      deq_cnt++;
    end
    @(posedge clk);
    #1;
    if (p && mem.size() != 0) fifo_q = mem.pop_front();
    set_flags();
    if (d) begin
      if (exp_q.size() == 0) chk("extra_word", 32'(d), 32'd0);
      else chk("data", 32'(s_dat), 32'(exp_q.pop_front()));
    end
    cyc++;
  endtask

  task automatic wait_deq(input string tag, input int n, input int budget);
    int k = 0;
    while (deq_cnt < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(deq_cnt), 32'(n));
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while ((busy || out_valid || exp_q.size() != 0 || mem.size() != 0) && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wc"}, 32'(word_count), 32'(exp_wc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    int pops_before;
    bit mid_done;
    reset             = 1'b1;
    out_ready         = 1'b0;
    fifo_q            = '0;
    fifo_error        = 1'b0;
    exp_wc            = '0;
    set_flags();
    clear_stats();
    #1 reset = 1'b0;
    #2;
    chk("rst_pop", 32'(fifo_pop), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;

    // Idle with an empty FIFO.
    for (int i = 0; i < 20; i++) step();
    chk("idle_pops", 32'(pop_cnt), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_wc", 32'(word_count), 32'd0);

    // Burst drain at full rate.
    clear_stats();
    load_seq(1, 7);
    wait_deq("burst_deq", 7, 40);
    chk("burst_pops", 32'(pop_cnt), 32'd7);
    chk("burst_pop_run", 32'(last_pop - first_pop), 32'd6);
    chk("burst_deq_run", 32'(last_deq - first_deq), 32'd6);
    // Pop registered at edge k -> out_valid rises at edge k+1, first seen in the sample before edge k+2.
    chk("burst_latency", 32'(first_vld - first_pop), 32'd2);
    chk("burst_saw_busy", 32'(saw_busy), 32'd1);
    drain("burst", 20);

    // Backpressure mid-burst.
    clear_stats();
    load_seq(8, 7);
    wait_deq("bp_pre", 2, 20);
    out_ready   = 1'b0;
    pops_before = pop_cnt;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(s_vld), 32'd1);
      chk("bp_hold", 32'(s_dat), 32'(exp_q[0]));
    end
    chk("bp_pops", 32'(pop_cnt - pops_before), 32'd0);
    chk("bp_no_deq", 32'(deq_cnt), 32'd2);
    out_ready = 1'b1;
    drain("bp", 40);

    // Timeout drain of a single residual word.
    clear_stats();
    load_seq(5, 1);
    for (int i = 0; i < TIMEOUT; i++) step();
    chk("to_early_pop", 32'(pop_cnt), 32'd0);
    k = 0;
    while (pop_cnt == 0 && k < 12) begin
      step();
      k++;
    end
    chk("to_pop", 32'(pop_cnt), 32'd1);
    drain("to", 20);

    // Asynchronous reset while the skid buffer is full.
    clear_stats();
    load_seq(0, 7);
    wait_deq("rst_pre", 2, 20);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("rst_pre_vld", 32'(s_vld), 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_pop", 32'(fifo_pop), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_wc", 32'(word_count), 32'd0);
    // Words already popped are gone; only what is still in the FIFO may appear.
    exp_q.delete();
    exp_wc = '0;
    foreach (mem[i]) begin
      exp_q.push_back(mem[i]);
      exp_wc = exp_wc + CNT_W'(1);
    end
    step();
    step();
    reset = 1'b1;
    chk("rel_wc", 32'(word_count), 32'd0);
    chk("rel_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    drain("rst", 60);

    // Sticky error and counter wrap.
    reset = 1'b0;
    step();
    reset  = 1'b1;
    exp_wc = '0;
    chk("err_after_rst", 32'(err), 32'd0);
    fifo_error = 1'b1;
    step();
    fifo_error = 1'b0;
    step();
    chk("err_set", 32'(err), 32'd1);
    clear_stats();
    load_seq(0, 256);
    mid_done = 1'b0;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      step();
      k++;
      if (!mid_done && exp_q.size() == 1) begin
        mid_done = 1'b1;
        chk("wc_255", 32'(word_count), 32'd255);
      end
    end
    drain("wrap", 40);
    chk("wrap_wc_zero", 32'(word_count), 32'd0);
    chk("err_sticky", 32'(err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_drain_ctrl.md
Name: fifo_drain_ctrl

Overview:
- Read-side controller for the 4-bit TLP FIFO. It issues pop, captures q_b after the FIFO's 1-cycle read latency, and presents words to a downstream consumer over a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with no word loss under backpressure.
- A burst/timeout state machine drains in bursts once the FIFO is no longer almost_empty, or after an idle timeout.

Parameters:
- DATA_W, 4, word width; matches FIFO data_a/q_b.
- TIMEOUT, 8, idle cycles with FIFO non-empty but almost_empty before a forced drain.
- TO_W, 4, width of the timeout counter; must hold TIMEOUT.
- CNT_W, 8, width of the delivered-word counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- fifo_q  in  DATA_W  FIFO q_b; valid the cycle after fifo_pop=1.
- fifo_empty  in  1  FIFO empty; registered, reflects all pops up to the previous edge.
- fifo_almost_empty  in  1  FIFO almost_empty.
- fifo_error  in  1  FIFO error flag.
- fifo_pop  out  1  pop request to FIFO.
- out_data  out  DATA_W  word to consumer.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid&&out_ready at a rising edge.
- busy  out  1  state != IDLE.
- err  out  1  sticky; set when fifo_error=1 at any edge.
- word_count  out  CNT_W  words delivered (handshakes), wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE; skid buffer empty (occ=0); inflight=0; timeout counter=0.
  - fifo_pop=0, out_valid=0, out_data=0, busy=0, err=0, word_count=0.
  - Reset mid-burst discards buffered and in-flight words; a q_b arriving after reset release is ignored because inflight=0.
- Skid buffer:
  - 2-entry FIFO-ordered register pair; out_data/out_valid come from the head entry.
  - occ is in 0..2.
  - inflight=1 in the cycle after fifo_pop=1; fifo_q is written into the buffer at that cycle's edge.
- Pop rule (combinational):
  - fifo_pop = (state==DRAIN) && !fifo_empty && (occ + inflight - deq < 2), where deq = out_valid && out_ready.
  - out_ready → fifo_pop is a combinational path; this is permitted.
  - Never pop when fifo_empty=1. Never pop in IDLE.
- Throughput:
  - With out_ready held at 1 and the FIFO non-empty, one pop and one delivery occur every cycle after a 2-cycle startup: pop at cycle N, out_valid at N+1.
- Simultaneous write and deq:
  - Head leaves, the incoming word joins, occ is unchanged.
  - Order is strictly preserved.
- Backpressure:
  - With out_ready=0, at most 2 words are held; pops stop once occ+inflight=2.
  - out_data is stable while out_valid && !out_ready.
- State machine IDLE / DRAIN:
  - IDLE → DRAIN when !fifo_empty && !fifo_almost_empty.
  - IDLE → DRAIN when the timeout counter reaches TIMEOUT.
  - In IDLE, the timeout counter increments each cycle !fifo_empty; it clears when fifo_empty=1 or on leaving IDLE.
  - DRAIN → IDLE when fifo_empty && inflight==0. The buffer may still hold words; delivery continues from IDLE.
- word_count increments by 1 on every deq edge; it wraps from 2^CNT_W-1 to 0.
- err:
  - Set on any edge with fifo_error=1; cleared only by reset.
  - Does not stop draining.

Test Plan:
- Reset release with FIFO empty: hold 20 cycles → fifo_pop=0, out_valid=0, busy=0, word_count=0.
- Burst drain: FIFO loaded with 0001..0111 (7 words, almost_empty deasserts), out_ready=1 → busy rises; 7 consecutive pops; out_data sequence 0001..0111 on 7 consecutive cycles starting 1 cycle after first pop; word_count=7; return to IDLE.
- Backpressure: during drain, out_ready=0 for 5 cycles → pops stop after occ+inflight=2; out_data frozen at the head word; after out_ready=1, words resume in order with no loss or duplicate.
- Timeout: FIFO holds 1 word (0101, almost_empty=1) → no pop for TIMEOUT=8 cycles; then one pop; out_data=0101 delivered; IDLE again.
- Async reset mid-burst: reset=0 between edges while occ=2 → out_valid, fifo_pop, busy fall immediately; after release, no stale word appears and word_count=0.
- Error and wrap: pulse fifo_error one cycle → err=1 and stays 1 through further drains; deliver 256 words with CNT_W=8 → word_count wraps to 0.
